// File: rtl/bus_io_bridge.sv
// Host-side byte FIFOs bridged to a processor 4-phase handshake port.
// TX carries host bytes to the processor; RX carries processor bytes to the host.
module bus_io_bridge #(
  parameter int unsigned DEPTH  = 4,
  parameter bit          IRQ_EN = 1'b1
) (
  input  logic       g_clk,
  input  logic       g_clr,
  input  logic [7:0] host_wr_data,
  input  logic       host_wr_en,
  output logic       host_full,
  output logic [7:0] host_rd_data,
  input  logic       host_rd_en,
  output logic       host_empty,
  output logic       host_err,
  output logic [7:0] proc_bus_in,
  output logic       proc_hs_in,
  input  logic [7:0] proc_bus_out,
  input  logic       proc_hs_out,
  input  logic       proc_dir,
  output logic       proc_irq
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {
    IDLE,
    ACK
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wp;
  logic [AW-1:0] tx_rp;
  logic [CW-1:0] tx_cnt;

  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wp;
  logic [AW-1:0] rx_rp;
  logic [CW-1:0] rx_cnt;

  logic tx_full;
  logic tx_empty;
  logic rx_full;
  logic rx_empty;

  logic tx_push;
  logic tx_pop;
  logic rx_push;
  logic rx_pop;
  logic bad_push;
  logic bad_pop;

  logic [7:0] bus_in_q;
  logic       hs_in_q;
  logic       irq_q;
  logic       err_q;

  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);

  // Handshake next-state and FIFO side effects of an accepted request
  always_comb begin
    state_d = state_q;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (proc_hs_out && !g_clr) begin
          if (proc_dir) begin
            if (!rx_full) begin
              rx_push = 1'b1;
              state_d = ACK;
            end
          end else begin
            if (!tx_empty) begin
              tx_pop  = 1'b1;
              state_d = ACK;
            end
          end
        end
      end
      ACK: begin
        if (!proc_hs_out) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Host strobe qualification; a push into a full TX is legal
  // only when the bridge frees a slot on the same edge
  always_comb begin
    tx_push  = 1'b0;
    rx_pop   = 1'b0;
    bad_push = 1'b0;
    bad_pop  = 1'b0;
    if (!g_clr) begin
      tx_push  = host_wr_en && (!tx_full || tx_pop);
      bad_push = host_wr_en && tx_full && !tx_pop;
      rx_pop   = host_rd_en && !rx_empty;
      bad_pop  = host_rd_en && rx_empty;
    end
  end

  // Handshake state register
  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // TX pointers and occupancy
  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) begin
        tx_wp <= tx_wp + AW'(1);
      end
      if (tx_pop) begin
        tx_rp <= tx_rp + AW'(1);
      end
      if (tx_push && !tx_pop) begin
        tx_cnt <= tx_cnt + CW'(1);
      end else if (!tx_push && tx_pop) begin
        tx_cnt <= tx_cnt - CW'(1);
      end
    end
  end

  // TX storage
  always_ff @(posedge g_clk) begin
    if (tx_push) begin
      tx_mem[tx_wp] <= host_wr_data;
    end
  end

  // RX pointers and occupancy
  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) begin
        rx_wp <= rx_wp + AW'(1);
      end
      if (rx_pop) begin
        rx_rp <= rx_rp + AW'(1);
      end
      if (rx_push && !rx_pop) begin
        rx_cnt <= rx_cnt + CW'(1);
      end else if (!rx_push && rx_pop) begin
        rx_cnt <= rx_cnt - CW'(1);
      end
    end
  end

  // RX storage
  always_ff @(posedge g_clk) begin
    if (rx_push) begin
      rx_mem[rx_wp] <= proc_bus_out;
    end
  end

  // Registered processor-side outputs and sticky misuse flag
  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      bus_in_q <= 8'h00;
      hs_in_q  <= 1'b0;
      irq_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (tx_pop) begin
        bus_in_q <= tx_mem[tx_rp];
      end
      hs_in_q <= (state_d == ACK);
      irq_q   <= IRQ_EN && !tx_empty;
      if (bad_push || bad_pop) begin
        err_q <= 1'b1;
      end
    end
  end

  assign host_full    = tx_full;
  assign host_empty   = rx_empty;
  assign host_rd_data = rx_empty ? 8'h00 : rx_mem[rx_rp];
  assign host_err     = err_q;
  assign proc_bus_in  = bus_in_q;
  assign proc_hs_in   = hs_in_q;
  assign proc_irq     = irq_q;

endmodule
